// File: rtl/fp_add_sub_pipe_if.sv
// fp_add_sub_pipe_if: operand/result stream bundle for the pipelined FP adder.
interface fp_add_sub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;
    logic         in_valid, in_ready, sub, out_valid, out_ready, overflow, underflow, invalid;
    logic [W-1:0] op_a, op_b, result;
    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, invalid
    );
    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, overflow, underflow, invalid
    );
endinterface

// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: 4-stage IEEE-754-style adder/subtractor, round-to-nearest-even,
// denormals flushed to zero, global-stall valid/ready stream.
module fp_add_sub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic              clk,
    input logic              rst_n,
    fp_add_sub_pipe_if.slave bus
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int SW  = MAN_W + 4;
    localparam int LZW = $clog2(SW + 1);
    localparam int NW  = EXP_W + 2;
    localparam logic [EXP_W-1:0] EMAX  = '1;
    localparam logic [EXP_W-1:0] SHMAX = EXP_W'(MAN_W + 3);
    localparam logic [W-1:0]     QNAN  = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    logic             adv, sa, sb, ia, ib, na, nb, za, zb, swap, inv1_d, esub1_q, esub2_q;
    logic             inc, zero, ovf, unf, ovf_q, unf_q, inv_q;
    logic [3:0]       v_q;
    logic [W+2:0]     ctl1_d;
    logic [W+2:0]     ctl_q [1:3];
    logic [EXP_W-1:0] ea, eb, e1_q, e2_q, e3_q, diff1_q, d2;
    logic [MAN_W-1:0] ma, mb;
    logic [MAN_W:0]   ml1_q, ms1_q, ml2_q;
    logic [SW-1:0]    ext, sh, al2_d, al2_q, nm;
    logic [SW:0]      sum3_d, sum3_q;
    logic [LZW-1:0]   lz3_d, lz3_q;
    logic [NW-1:0]    ne, fe;
    logic [MAN_W+1:0] rm;
    logic [W-1:0]     res4_d, res_q;

    assign adv            = !v_q[3] || bus.out_ready;
    assign bus.in_ready   = adv;
    assign bus.out_valid  = v_q[3];
    assign bus.result     = res_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
    assign bus.invalid    = inv_q;

    // Specials are fully resolved here; ctl = {special, invalid, sign, special result}.
    always_comb begin
        sa     = bus.op_a[W-1];
        sb     = bus.op_b[W-1] ^ bus.sub;
        ea     = bus.op_a[W-2:MAN_W];
        eb     = bus.op_b[W-2:MAN_W];
        za     = ea == '0;
        zb     = eb == '0;
        ma     = za ? '0 : bus.op_a[MAN_W-1:0];
        mb     = zb ? '0 : bus.op_b[MAN_W-1:0];
        ia     = ea == EMAX && ma == '0;
        ib     = eb == EMAX && mb == '0;
        na     = ea == EMAX && ma != '0;
        nb     = eb == EMAX && mb != '0;
        swap   = {eb, mb} > {ea, ma};
        inv1_d = na || nb || (ia && ib && sa != sb);
        ctl1_d = {na || nb || ia || ib || za || zb, inv1_d, swap ? sb : sa,
                  inv1_d ? QNAN : ia ? {sa, ea, ma} : ib ? {sb, eb, mb} :
                  (za && zb) ? {sa && sb, {(W-1){1'b0}}} : za ? {sb, eb, mb} : {sa, ea, ma}};
    end

    // Alignment keeps guard/round in the two bits below the LSB; bit 0 collects the sticky OR.
    always_comb begin
        d2    = diff1_q > SHMAX ? SHMAX : diff1_q;
        ext   = {ms1_q, 3'b000};
        sh    = ext >> d2;
        al2_d = {sh[SW-1:1], sh[0] | (|(ext & ~({SW{1'b1}} << d2)))};
    end

    always_comb begin
        sum3_d = esub2_q ? {1'b0, ml2_q, 3'b000} - {1'b0, al2_q} : {1'b0, ml2_q, 3'b000} + {1'b0, al2_q};
        lz3_d  = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (sum3_d[i]) lz3_d = LZW'(SW - 1 - i);
    end

    always_comb begin
        nm     = sum3_q[SW] ? {sum3_q[SW:2], sum3_q[1] | sum3_q[0]} : sum3_q[SW-1:0] << lz3_q;
        ne     = sum3_q[SW] ? NW'(e3_q) + NW'(1) : NW'(e3_q) - NW'(lz3_q);
        inc    = nm[2] && (nm[1] || nm[0] || nm[3]);
        rm     = {1'b0, nm[SW-1:3]} + (MAN_W+2)'(inc);
        fe     = ne + NW'(rm[MAN_W+1]);
        zero   = sum3_q == '0;
        ovf    = !zero && !fe[NW-1] && fe >= NW'(EMAX);
        unf    = !zero && (fe[NW-1] || fe == '0);
        res4_d = ctl_q[3][W+2] ? ctl_q[3][W-1:0] : zero ? '0 :
                 ovf ? {ctl_q[3][W], EMAX, {MAN_W{1'b0}}} :
                 unf ? {ctl_q[3][W], {(W-1){1'b0}}} :
                 {ctl_q[3][W], fe[EXP_W-1:0], rm[MAN_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            ctl_q   <= '{default: '0};
            esub1_q <= 1'b0;
            esub2_q <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            e3_q    <= '0;
            diff1_q <= '0;
            ml1_q   <= '0;
            ms1_q   <= '0;
            ml2_q   <= '0;
            al2_q   <= '0;
            sum3_q  <= '0;
            lz3_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else if (adv) begin
            v_q     <= {v_q[2:0], bus.in_valid};
            ctl_q[1] <= ctl1_d;
            ctl_q[2] <= ctl_q[1];
            ctl_q[3] <= ctl_q[2];
            esub1_q <= sa ^ sb;
            e1_q    <= swap ? eb : ea;
            diff1_q <= swap ? eb - ea : ea - eb;
            ml1_q   <= swap ? {1'b1, mb} : {1'b1, ma};
            ms1_q   <= swap ? {1'b1, ma} : {1'b1, mb};
            esub2_q <= esub1_q;
            e2_q    <= e1_q;
            ml2_q   <= ml1_q;
            al2_q   <= al2_d;
            e3_q    <= e2_q;
            sum3_q  <= sum3_d;
            lz3_q   <= lz3_d;
            res_q   <= res4_d;
            ovf_q   <= !ctl_q[3][W+2] && ovf;
            unf_q   <= !ctl_q[3][W+2] && unf;
            inv_q   <= ctl_q[3][W+2] && ctl_q[3][W+1];
        end
    end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// tb_fp_add_sub_pipe: directed and randomized checks of the FP adder (single and half formats)
// against a real-arithmetic reference model.
module tb_fp_add_sub_pipe;
    logic clk = 1'b0, rst_n = 1'b0;
    int   checks = 0, errors = 0;
    logic [64:0] stim[$];

    always #5 clk = ~clk;

    fp_add_sub_pipe_if #(.EXP_W(8), .MAN_W(23)) bf ();
    fp_add_sub_pipe_if #(.EXP_W(5), .MAN_W(10)) bh ();
    fp_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .rst_n(rst_n), .bus(bf));
    fp_add_sub_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .rst_n(rst_n), .bus(bh));

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(int ew, int mw, logic s, int e, longint f);
        return (32'(s) << (ew + mw)) | (32'(e) << mw) | 32'(f);
    endfunction

    function automatic real to_real(int ew, int mw, logic s, int x, longint f);
        int bias = (1 << (ew - 1)) - 1;
        logic [63:0] d = {s, 63'b0};
        if (x != 0) d = {s, 11'(x - bias + 1023), 52'(f << (52 - mw))};
        return $bitstoreal(d);
    endfunction

    // Exact double sum then one RNE rounding to the target format; returns {invalid, overflow, underflow, result}.
    function automatic logic [34:0] model(int ew, int mw, logic [31:0] a, logic [31:0] b, logic sub);
        int     emax = (1 << ew) - 1;
        int     bias = (1 << (ew - 1)) - 1;
        int     k = 52 - mw;
        int     xa = int'((a >> mw) & 32'(emax));
        int     xb = int'((b >> mw) & 32'(emax));
        longint fa = longint'(a & ((32'd1 << mw) - 32'd1));
        longint fb = longint'(b & ((32'd1 << mw) - 32'd1));
        logic   sa = a[ew + mw];
        logic   sb = b[ew + mw] ^ sub;
        bit     na = xa == emax && fa != 0, nb = xb == emax && fb != 0;
        bit     ia = xa == emax && fa == 0, ib = xb == emax && fb == 0;
        logic [63:0] d;
        longint keep, rem, half;
        int     te;
        if (na || nb || (ia && ib && sa != sb)) return {3'b100, 32'((emax << mw) | (1 << (mw - 1)))};
        if (ia) return {3'b000, pack(ew, mw, sa, emax, 0)};
        if (ib) return {3'b000, pack(ew, mw, sb, emax, 0)};
        d = $realtobits(to_real(ew, mw, sa, xa, fa) + to_real(ew, mw, sb, xb, fb));
        if (d[62:52] == 11'd0) return {3'b000, pack(ew, mw, d[63], 0, 0)};
        te   = int'(d[62:52]) - 1023 + bias;
        keep = longint'(d[51:0] >> k);
        rem  = longint'(d[51:0]) & ((64'sd1 << k) - 64'sd1);
        half = 64'sd1 << (k - 1);
        if (rem > half || (rem == half && keep[0])) keep++;
        if (keep == (64'sd1 << mw)) begin
            keep = 0;
            te++;
        end
        if (te >= emax) return {3'b010, pack(ew, mw, d[63], emax, 0)};
        if (te <= 0) return {3'b001, pack(ew, mw, d[63], 0, 0)};
        return {3'b000, pack(ew, mw, d[63], te, keep)};
    endfunction

    function automatic logic [31:0] rnd_op(bit near);
        int c = $urandom_range(0, 19);
        logic [31:0] v = $urandom;
        if (c == 0) return {v[31], 31'h0};
        if (c == 1) return {v[31], 8'hFF, 23'h0};
        if (c == 2) return {v[31], 8'hFF, 1'b1, v[21:0]};
        if (c == 3) v[30:23] = 8'hFE;
        else if (c == 4) v[30:23] = 8'($urandom_range(1, 2));
        else if (near) v[30:23] = 8'(124 + $urandom_range(0, 6));
        else if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h80;
        return v;
    endfunction

    task automatic single(string tag, bit hp, logic [31:0] a, logic [31:0] b, logic s, logic [34:0] exp);
        int lat = 1;
        if (hp) begin
            bh.op_a = a[15:0]; bh.op_b = b[15:0]; bh.sub = s; bh.in_valid = 1'b1;
        end else begin
            bf.op_a = a; bf.op_b = b; bf.sub = s; bf.in_valid = 1'b1;
        end
        @(negedge clk);
        bf.in_valid = 1'b0;
        bh.in_valid = 1'b0;
        while (!(hp ? bh.out_valid : bf.out_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check(tag, hp ? {bh.invalid, bh.overflow, bh.underflow, 16'h0, bh.result}
                      : {bf.invalid, bf.overflow, bf.underflow, bf.result}, 64'(exp));
        @(negedge clk);
    endtask

    // mode 0: out_ready follows 1,0,0,1,0,0...; mode 1: random out_ready.
    task automatic stream(string tag, int mode);
        logic [34:0] exp_q[$];
        logic [34:0] held = '0, e;
        bit stalled = 0;
        int sent = 0, got = 0, cyc = 0, n = stim.size();
        while (got < n && cyc < 50 * n + 50) begin
            bf.in_valid = sent < n;
            if (sent < n) {bf.sub, bf.op_a, bf.op_b} = stim[sent];
            bf.out_ready = mode == 0 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (stalled)
                check({tag, "_hold"}, {bf.out_valid, bf.invalid, bf.overflow, bf.underflow, bf.result}, {1'b1, held});
            check({tag, "_in_ready"}, 64'(bf.in_ready), 64'(!(bf.out_valid && !bf.out_ready)));
            if (bf.out_valid && bf.out_ready) begin
                e = 'x;
                if (exp_q.size() != 0) e = exp_q.pop_front();
                check({tag, "_result"}, {bf.invalid, bf.overflow, bf.underflow, bf.result}, 64'(e));
                got++;
            end
            if (bf.in_valid && bf.in_ready) begin
                exp_q.push_back(model(8, 23, stim[sent][63:32], stim[sent][31:0], stim[sent][64]));
                sent++;
            end
            stalled = bf.out_valid && !bf.out_ready;
            held = {bf.invalid, bf.overflow, bf.underflow, bf.result};
            @(negedge clk);
            cyc++;
        end
        bf.in_valid = 1'b0;
        bf.out_ready = 1'b1;
        check({tag, "_count"}, 64'(got), 64'(n));
        check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int stale = 0;
        bf.in_valid = 1'b0; bf.out_ready = 1'b1; bf.op_a = '0; bf.op_b = '0; bf.sub = 1'b0;
        bh.in_valid = 1'b0; bh.out_ready = 1'b1; bh.op_a = '0; bh.op_b = '0; bh.sub = 1'b0;
        #12;
        check("reset_sp", {bf.out_valid, bf.invalid, bf.overflow, bf.underflow, bf.result}, 64'd0);
        check("reset_hp", {bh.out_valid, bh.invalid, bh.overflow, bh.underflow, bh.result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 64'(bf.in_ready), 64'd1);
        @(negedge clk);

        single("one_plus_one", 0, 32'h3F800000, 32'h3F800000, 1'b0, {3'b000, 32'h40000000});
        single("x_minus_x", 0, 32'h3F800000, 32'h3F800000, 1'b1, {3'b000, 32'h00000000});
        single("neg_zeros", 0, 32'h80000000, 32'h80000000, 1'b0, {3'b000, 32'h80000000});
        single("tie_even", 0, 32'h3F800000, 32'h33800000, 1'b0, {3'b000, 32'h3F800000});
        single("above_tie", 0, 32'h3F800000, 32'h33800001, 1'b0, {3'b000, 32'h3F800001});
        single("tie_odd", 0, 32'h3F800001, 32'h33800000, 1'b0, {3'b000, 32'h3F800002});
        single("overflow", 0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {3'b010, 32'h7F800000});
        single("inf_minus_inf", 0, 32'h7F800000, 32'hFF800000, 1'b0, {3'b100, 32'h7FC00000});
        single("nan_in", 0, 32'h7FC00001, 32'h3F800000, 1'b0, {3'b100, 32'h7FC00000});
        single("inf_finite", 0, 32'hFF800000, 32'h3F800000, 1'b0, {3'b000, 32'hFF800000});
        single("denorm_flush", 0, 32'h00000001, 32'h3F800000, 1'b0, {3'b000, 32'h3F800000});
        single("underflow", 0, 32'h00800001, 32'h00800000, 1'b1, {3'b001, 32'h00000000});
        single("two_minus_one", 0, 32'h40000000, 32'h3F800000, 1'b1, {3'b000, 32'h3F800000});
        single("hp_one_plus_one", 1, 32'h3C00, 32'h3C00, 1'b0, {3'b000, 32'h4000});
        single("hp_overflow", 1, 32'h7BFF, 32'h7BFF, 1'b0, {3'b010, 32'h7C00});
        single("hp_x_minus_x", 1, 32'h3C00, 32'h3C00, 1'b1, {3'b000, 32'h0000});

        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back({1'($urandom_range(0, 1)), rnd_op(1), rnd_op(1)});
        stream("backpressure", 0);
        stim.delete();
        for (int i = 0; i < 60; i++) begin
            bit near = 1'($urandom_range(0, 1));
            stim.push_back({1'($urandom_range(0, 1)), rnd_op(near), rnd_op(near)});
        end
        stream("random", 1);

        bf.out_ready = 1'b0;
        bf.op_a = 32'h3F800000; bf.op_b = 32'h40000000; bf.sub = 1'b0;
        bf.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bf.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_stalled", 64'(bf.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {bf.out_valid, bf.invalid, bf.overflow, bf.underflow, bf.result}, 64'd0);
        @(negedge clk);
        bf.out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rerelease", 64'(bf.in_ready), 64'd1);
        repeat (8) begin
            @(negedge clk);
            stale += int'(bf.out_valid);
        end
        check("no_stale_after_reset", 64'(stale), 64'd0);
        single("after_reset", 0, 32'h40000000, 32'h40000000, 1'b0, {3'b000, 32'h40800000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
